upsp_nn_scaler: RTL and testbench

UPSP_NN_SCALER -- requirements
Module: upsp_nn_scaler

---
 rtl/upsp_nn_scaler_if.sv | 31 +++
 rtl/upsp_nn_scaler.sv | 151 +++++++++++++++
 tb/tb_upsp_nn_scaler.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/upsp_nn_scaler_if.sv
// Pixel read/write channel between the nearest-neighbour upscaler and
// access_control. The scaler is the master: it raises the read and write
// requests, and access_control answers with rvalid/rdata and wready.
interface upsp_nn_scaler_if #(
  parameter int UPSP_DATA_WIDTH = 24
);
  logic                       upsp_ac_rd;
  logic                       ac_upsp_rvalid;
  logic [UPSP_DATA_WIDTH-1:0] ac_upsp_rdata;
  logic                       upsp_ac_wrt;
  logic [UPSP_DATA_WIDTH-1:0] upsp_ac_wdata;
  logic                       ac_upsp_wready;

  modport master (
    output upsp_ac_rd,
    output upsp_ac_wrt,
    output upsp_ac_wdata,
    input  ac_upsp_rvalid,
    input  ac_upsp_rdata,
    input  ac_upsp_wready
  );

  modport slave (
    input  upsp_ac_rd,
    input  upsp_ac_wrt,
    input  upsp_ac_wdata,
    output ac_upsp_rvalid,
    output ac_upsp_rdata,
    output ac_upsp_wready
  );
endinterface

// File: rtl/upsp_nn_scaler.sv
// Nearest-neighbour integer upscaler. The scaler buffers one source line,
// then writes it out SCALE times, with every pixel repeated SCALE times.
//
// state | meaning
// IDLE  | waiting for a rising edge on UPSTR[0]
// FILL  | reading one source line into the line buffer
// EMIT  | writing the buffered line SCALE times, each pixel SCALE times
// DONE  | one-cycle completion pulse, then back to IDLE
module upsp_nn_scaler #(
  parameter int UPSP_DATA_WIDTH = 24,
  parameter int CRF_DATA_WIDTH  = 32,
  parameter int SRC_IMG_WIDTH   = 960,
  parameter int SRC_IMG_HEIGHT  = 540,
  parameter int SCALE           = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CRF_DATA_WIDTH-1:0] UPSTR,
  input  logic [CRF_DATA_WIDTH-1:0] UPENDR,
  upsp_nn_scaler_if.master          bus,
  output logic                      upsp_busy,
  output logic                      upsp_done
);

  localparam int SXW = (SRC_IMG_WIDTH  > 1) ? $clog2(SRC_IMG_WIDTH)  : 1;
  localparam int SYW = (SRC_IMG_HEIGHT > 1) ? $clog2(SRC_IMG_HEIGHT) : 1;
  localparam int SCW = (SCALE          > 1) ? $clog2(SCALE)          : 1;

  localparam logic [SXW-1:0] SX_LAST = SXW'(SRC_IMG_WIDTH - 1);
  localparam logic [SYW-1:0] SY_LAST = SYW'(SRC_IMG_HEIGHT - 1);
  localparam logic [SCW-1:0] SC_LAST = SCW'(SCALE - 1);

  typedef enum logic [1:0] {IDLE, FILL, EMIT, DONE} state_t;

  state_t state, state_nxt;

  logic [UPSP_DATA_WIDTH-1:0] line_buf [SRC_IMG_WIDTH];
  logic [SXW-1:0] sx;
  logic [SCW-1:0] rx, ry;
  logic [SYW-1:0] sy;
  logic start_prev;

  logic start_pulse, abort, rd_hs, wr_hs;
  logic sx_last, rx_last, ry_last, sy_last;

  // Only bit 0 of the control words carries meaning.
  logic unused_crf_bits;
  assign unused_crf_bits = ^{UPSTR[CRF_DATA_WIDTH-1:1], UPENDR[CRF_DATA_WIDTH-1:1]};

  assign start_pulse = UPSTR[0] && !start_prev;
  assign abort       = UPENDR[0] && ((state == FILL) || (state == EMIT));
  assign rd_hs       = bus.upsp_ac_rd  && bus.ac_upsp_rvalid;
  assign wr_hs       = bus.upsp_ac_wrt && bus.ac_upsp_wready;
  assign sx_last     = (sx == SX_LAST);
  assign rx_last     = (rx == SC_LAST);
  assign ry_last     = (ry == SC_LAST);
  assign sy_last     = (sy == SY_LAST);

  // State register and start-edge history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      start_prev <= 1'b0;
    end else begin
      state      <= state_nxt;
      start_prev <= UPSTR[0];
    end
  end

  // Next state and channel outputs; abort wins over every other transition.
  always_comb begin
    state_nxt         = state;
    bus.upsp_ac_rd    = 1'b0;
    bus.upsp_ac_wrt   = 1'b0;
    bus.upsp_ac_wdata = '0;
    upsp_busy         = (state != IDLE);
    upsp_done         = 1'b0;
    case (state)
      IDLE: if (start_pulse) state_nxt = FILL;
      FILL: begin
        bus.upsp_ac_rd = 1'b1;
        if (abort)                   state_nxt = IDLE;
        else if (rd_hs && sx_last)   state_nxt = EMIT;
      end
      EMIT: begin
        bus.upsp_ac_wrt   = 1'b1;
        bus.upsp_ac_wdata = line_buf[sx];
        if (abort)                                     state_nxt = IDLE;
        else if (wr_hs && rx_last && sx_last && ry_last) state_nxt = sy_last ? DONE : FILL;
      end
      DONE: begin
        upsp_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Source/replica counters; a handshake in the abort cycle still advances them.
  always_ff @(posedge clk) begin
    if (rst) begin
      sx <= '0;
      rx <= '0;
      ry <= '0;
      sy <= '0;
    end else begin
      case (state)
        IDLE: if (start_pulse) begin
          sx <= '0;
          rx <= '0;
          ry <= '0;
          sy <= '0;
        end
        FILL: if (rd_hs) begin
          if (sx_last) begin
            sx <= '0;
            rx <= '0;
            ry <= '0;
          end else begin
            sx <= sx + 1'b1;
          end
        end
        EMIT: if (wr_hs) begin
          if (!rx_last) begin
            rx <= rx + 1'b1;
          end else begin
            rx <= '0;
            if (!sx_last) begin
              sx <= sx + 1'b1;
            end else begin
              sx <= '0;
              if (!ry_last) begin
                ry <= ry + 1'b1;
              end else if (!sy_last) begin
                ry <= '0;
                sy <= sy + 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Line buffer is plain storage without reset so it can map to RAM.
  always_ff @(posedge clk) begin
    if (!rst && rd_hs) line_buf[sx] <= bus.ac_upsp_rdata;
  end

endmodule

// File: tb/tb_upsp_nn_scaler.sv
// Directed bench for the upscaler at 4x2 source, SCALE 2, 8-bit pixels.
// Source pixels are 1..8 in read order; the expected write stream is
// hand-derived as row r, pixel c -> value r*4 + c + 1.
module tb_upsp_nn_scaler;

  logic        clk;
  logic        rst;
  logic [31:0] UPSTR;
  logic [31:0] UPENDR;
  logic        upsp_busy;
  logic        upsp_done;

  upsp_nn_scaler_if #(.UPSP_DATA_WIDTH(8)) bus ();

  upsp_nn_scaler #(
    .UPSP_DATA_WIDTH(8),
    .CRF_DATA_WIDTH (32),
    .SRC_IMG_WIDTH  (4),
    .SRC_IMG_HEIGHT (2),
    .SCALE          (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .UPSTR    (UPSTR),
    .UPENDR   (UPENDR),
    .bus      (bus),
    .upsp_busy(upsp_busy),
    .upsp_done(upsp_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  int mode = 0;     // 0: all ready, 1: wready alternating, 2: rvalid every 3rd cycle
  int cyc  = 0;
  int rd_idx = 0;
  logic rd_hs_seen = 1'b0;

  int wq [$];
  int wr_rd [$];
  int rd_total = 0;
  int done_cnt = 0;
  int done_after = -1;
  int stab_err = 0;
  int overlap = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  assign bus.ac_upsp_rdata = (bus.ac_upsp_rvalid && rd_idx < 8) ? 8'(rd_idx + 1) : 8'hEE;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Observe the channel mid-cycle, away from the active edge.
  always @(negedge clk) begin
    rd_hs_seen = bus.upsp_ac_rd && bus.ac_upsp_rvalid;
    if (rd_hs_seen) rd_total++;
    if (bus.upsp_ac_wrt && bus.ac_upsp_wready) begin
      wq.push_back(int'(bus.upsp_ac_wdata));
      wr_rd.push_back(rd_total);
    end
    if (upsp_done) begin
      done_cnt++;
      done_after = wq.size();
    end
    if (prev_stall && bus.upsp_ac_wrt && bus.upsp_ac_wdata != prev_data) stab_err++;
    if (bus.upsp_ac_rd && bus.upsp_ac_wrt) overlap++;
    prev_stall = bus.upsp_ac_wrt && !bus.ac_upsp_wready;
    prev_data  = bus.upsp_ac_wdata;
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rd_hs_seen) rd_idx++;
    cyc++;
    case (mode)
      1:       begin bus.ac_upsp_rvalid = 1'b1;          bus.ac_upsp_wready = cyc[0]; end
      2:       begin bus.ac_upsp_rvalid = (cyc % 3 == 0); bus.ac_upsp_wready = 1'b1;  end
      default: begin bus.ac_upsp_rvalid = 1'b1;          bus.ac_upsp_wready = 1'b1;  end
    endcase
  endtask

  task automatic start_frame();
    wq.delete();
    wr_rd.delete();
    rd_total   = 0;
    rd_idx     = 0;
    done_cnt   = 0;
    done_after = -1;
    UPSTR[0]   = 1'b1;
    step();
    UPSTR[0]   = 1'b0;
  endtask

  task automatic run_until(input int target, input string tag);
    int budget = 600;
    while (wq.size() < target && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) chk({tag, "_timeout"}, wq.size(), target);
  endtask

  task automatic verify_full(input string tag);
    for (int i = 0; i < 6; i++) step();
    chk({tag, "_nwrites"}, wq.size(), 32);
    for (int k = 0; k < 32 && k < wq.size(); k++) begin
      chk($sformatf("%s_w%0d", tag, k), wq[k], (k / 16) * 4 + (k % 8) / 2 + 1);
      chk($sformatf("%s_rdorder%0d", tag, k), wr_rd[k], 4 * (k / 16 + 1));
    end
    chk({tag, "_ndone"}, done_cnt, 1);
    chk({tag, "_done_after"}, done_after, 32);
    chk({tag, "_busy_end"}, int'(upsp_busy), 0);
  endtask

  initial begin
    rst = 1'b1;
    UPSTR = '0;
    UPENDR = '0;
    bus.ac_upsp_rvalid = 1'b0;
    bus.ac_upsp_wready = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_busy", int'(upsp_busy), 0);
    chk("rst_done", int'(upsp_done), 0);
    chk("rst_rd",   int'(bus.upsp_ac_rd), 0);
    chk("rst_wrt",  int'(bus.upsp_ac_wrt), 0);
    chk("rst_wdata", int'(bus.upsp_ac_wdata), 0);
    step();

    // Plain frame with both channels always ready.
    mode = 0;
    start_frame();
    run_until(32, "basic");
    verify_full("basic");

    // Write back-pressure on alternate cycles.
    mode = 1;
    stab_err = 0;
    start_frame();
    run_until(32, "wstall");
    verify_full("wstall");
    chk("wstall_stable", stab_err, 0);

    // Sparse read data; rdata is garbage whenever rvalid is low.
    mode = 2;
    start_frame();
    run_until(32, "rsparse");
    verify_full("rsparse");

    // Abort after the 5th write; the write in the abort cycle still lands.
    mode = 0;
    start_frame();
    run_until(5, "abort");
    UPENDR[0] = 1'b1;
    step();
    chk("abort_rd",   int'(bus.upsp_ac_rd), 0);
    chk("abort_wrt",  int'(bus.upsp_ac_wrt), 0);
    chk("abort_busy", int'(upsp_busy), 0);
    UPENDR[0] = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("abort_nwrites", wq.size(), 6);
    chk("abort_ndone", done_cnt, 0);
    start_frame();
    run_until(32, "post_abort");
    verify_full("post_abort");

    // A fresh start edge in the middle of EMIT is ignored.
    start_frame();
    run_until(10, "restart");
    UPSTR[0] = 1'b1;
    step();
    UPSTR[0] = 1'b0;
    run_until(32, "restart");
    verify_full("restart");

    // Reset mid-EMIT, then a new frame from the top.
    start_frame();
    run_until(6, "midrst");
    rst = 1'b1;
    step();
    chk("midrst_busy",  int'(upsp_busy), 0);
    chk("midrst_rd",    int'(bus.upsp_ac_rd), 0);
    chk("midrst_wrt",   int'(bus.upsp_ac_wrt), 0);
    chk("midrst_wdata", int'(bus.upsp_ac_wdata), 0);
    chk("midrst_done",  int'(upsp_done), 0);
    step();
    rst = 1'b0;
    step();
    start_frame();
    run_until(32, "post_rst");
    verify_full("post_rst");

    chk("rd_wrt_overlap", overlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
